// File: rtl/x3q16_defs_pkg.sv
// rtl/x3q16_defs_pkg.sv - shared request codes and responder state encoding for the x3q16 memory path
package x3q16_defs;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

endpackage

// File: rtl/x3q16_sram.sv
// rtl/x3q16_sram.sv - single-port 16-bit synchronous RAM with strobed, registered read port
module x3q16_sram #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  logic [15:0] mem [2**ADDR_BITS];

  // Array write; deliberately not reset so contents survive a core reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register only loads on a read strobe, so it holds the last read word
  always_ff @(posedge clk) begin
    if (reset)   rdata <= 16'h0000;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/x3q16_mem_responder.sv
// rtl/x3q16_mem_responder.sv - request/ready memory responder with wait states; X3Q16_MEM_WPROT_EN enables low-address write protection
module x3q16_mem_responder
  import x3q16_defs::*;
#(
  parameter int          ADDR_BITS  = 12,
  parameter int          LATENCY    = 2,
  parameter logic [15:0] PROT_LIMIT = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request,
  input  logic        request_type,
  input  logic [15:0] request_address,
  input  logic [15:0] data_out,
  output logic [15:0] memory_in,
  output logic        memory_ready,
  output logic        write_complete,
  output logic        overrun,
  output logic        wprot_hit
);

  resp_state_t          state;
  logic [3:0]           cnt;
  logic                 lat_type;
  logic [ADDR_BITS-1:0] lat_addr;
  logic [15:0]          lat_data;
  logic                 lat_prot;

  logic addr_below_limit;
  logic write_blocked;
  logic enter_resp;
  logic ram_we;
  logic ram_re;

  // Protection compares the full 16-bit address, before aliasing
  assign addr_below_limit = (request_address < PROT_LIMIT);

`ifdef X3Q16_MEM_WPROT_EN
  assign write_blocked = lat_prot;
`else
  logic unused_prot;
  assign write_blocked = 1'b0;
  assign unused_prot   = lat_prot;
`endif

  // The edge that moves WAIT into RESP is the one that touches the RAM;
  // reset on that edge abandons the access.
  assign enter_resp = (state == WAIT) && (cnt == 4'd0);
  assign ram_we     = !reset && enter_resp && (lat_type == REQ_WRITE) && !write_blocked;
  assign ram_re     = !reset && enter_resp && (lat_type == REQ_READ);

  // Request latches, wait-state countdown and registered response pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      memory_ready   <= 1'b0;
      write_complete <= 1'b0;
      overrun        <= 1'b0;
      wprot_hit      <= 1'b0;
    end else begin
      memory_ready   <= 1'b0;
      write_complete <= 1'b0;
      wprot_hit      <= 1'b0;
      overrun        <= request && (state != IDLE);
      case (state)
        IDLE: begin
          if (request) begin
            lat_type <= request_type;
            lat_addr <= request_address[ADDR_BITS-1:0];
            lat_data <= data_out;
            lat_prot <= addr_below_limit;
            cnt      <= 4'(LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state          <= RESP;
            memory_ready   <= (lat_type == REQ_READ);
            write_complete <= (lat_type == REQ_WRITE);
            wprot_hit      <= (lat_type == REQ_WRITE) && write_blocked;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  x3q16_sram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_sram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (lat_addr),
    .wdata (lat_data),
    .rdata (memory_in)
  );

endmodule

// File: tb/tb_x3q16_mem_responder.sv
// tb/tb_x3q16_mem_responder.sv - self-checking bench for x3q16_mem_responder at LATENCY 2 and 1
module tb_x3q16_mem_responder;

  localparam int NCYC = 1500;

  typedef struct {
    bit          v;
    bit          w;
    bit          blk;
    bit [11:0]   a;
    logic [15:0] d;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        request = 1'b0;
  logic        request_type = 1'b0;
  logic [15:0] request_address = 16'h0;
  logic [15:0] data_out = 16'h0;

  logic [15:0] mi [2];
  logic        mr [2];
  logic        wc [2];
  logic        ov [2];
  logic        wp [2];

  always #5 clk = ~clk;

  x3q16_mem_responder #(.ADDR_BITS(12), .LATENCY(2), .PROT_LIMIT(16'h0100)) u0 (
    .clk(clk), .reset(reset), .request(request), .request_type(request_type),
    .request_address(request_address), .data_out(data_out),
    .memory_in(mi[0]), .memory_ready(mr[0]), .write_complete(wc[0]),
    .overrun(ov[0]), .wprot_hit(wp[0]));

  x3q16_mem_responder #(.ADDR_BITS(12), .LATENCY(1), .PROT_LIMIT(16'h0100)) u1 (
    .clk(clk), .reset(reset), .request(request), .request_type(request_type),
    .request_address(request_address), .data_out(data_out),
    .memory_in(mi[1]), .memory_ready(mr[1]), .write_complete(wc[1]),
    .overrun(ov[1]), .wprot_hit(wp[1]));

  txn_t        tq   [2][NCYC];
  bit          eov  [2][NCYC];
  bit          erst [NCYC];
  logic [15:0] mmem [2][4096];
  bit          mk   [2][4096];
  int          busy_end [2];
  logic [15:0] cur_mi [2];
  bit          cur_known [2];

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int n_rdy [2];
  int n_wc  [2];
  int n_ov  [2];
  int n_wp  [2];
  int last_rdy [2];
  int last_wc  [2];
  logic [15:0] last_rdata [2];

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, i, cyc, act, exp);
  endtask

  // Apply the rules to this cycle's inputs: accept when idle, else flag an overrun
  task automatic model_inputs();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int j = cyc + 1; j < NCYC; j++) begin
          tq[i][j].v = 1'b0;
          eov[i][j]  = 1'b0;
        end
        if (cyc + 1 < NCYC) erst[cyc + 1] = 1'b1;
        busy_end[i] = cyc;
      end else if (request) begin
        if (cyc > busy_end[i]) begin
          int p = cyc + lat(i) + 1;
          busy_end[i] = p;
          if (p < NCYC) begin
            tq[i][p].v = 1'b1;
            tq[i][p].w = request_type;
`ifdef X3Q16_MEM_WPROT_EN
            tq[i][p].blk = (request_address < 16'h0100);
`else
            tq[i][p].blk = 1'b0;
`endif
            tq[i][p].a = request_address[11:0];
            tq[i][p].d = data_out;
          end
        end else if (cyc + 1 < NCYC) begin
          eov[i][cyc + 1] = 1'b1;
        end
      end
    end
  endtask

  // Compare every output of both instances against the model for this cycle
  task automatic model_check();
    for (int i = 0; i < 2; i++) begin
      txn_t t = tq[i][cyc];
      bit e_rdy = t.v && !t.w;
      bit e_wc  = t.v && t.w;
      bit e_wp  = t.v && t.w && t.blk;
      if (erst[cyc]) begin
        cur_mi[i]    = 16'h0;
        cur_known[i] = 1'b1;
      end
      if (t.v) begin
        if (t.w) begin
          if (!t.blk) begin
            mmem[i][t.a] = t.d;
            mk[i][t.a]   = 1'b1;
          end
        end else begin
          cur_mi[i]    = mmem[i][t.a];
          cur_known[i] = mk[i][t.a];
        end
      end
      if (cyc >= 1) begin
        chk("memory_ready", i, 32'(mr[i]), 32'(e_rdy));
        chk("write_complete", i, 32'(wc[i]), 32'(e_wc));
        chk("overrun", i, 32'(ov[i]), 32'(eov[i][cyc]));
        chk("wprot_hit", i, 32'(wp[i]), 32'(e_wp));
        chk("ready_wc_overlap", i, 32'(mr[i] & wc[i]), 32'd0);
        if (cur_known[i]) chk("memory_in", i, 32'(mi[i]), 32'(cur_mi[i]));
      end
      if (mr[i] === 1'b1) begin
        n_rdy[i]++;
        last_rdy[i]   = cyc;
        last_rdata[i] = mi[i];
      end
      if (wc[i] === 1'b1) begin
        n_wc[i]++;
        last_wc[i] = cyc;
      end
      if (ov[i] === 1'b1) n_ov[i]++;
      if (wp[i] === 1'b1) n_wp[i]++;
    end
  endtask

  task automatic step(input logic r, input logic rq, input logic ty, input logic [15:0] ad, input logic [15:0] dt);
    @(posedge clk);
    #1;
    reset           = r;
    request         = rq;
    request_type    = ty;
    request_address = ad;
    data_out        = dt;
    model_inputs();
    @(negedge clk);
    model_check();
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  int rc;
  int snap [2];
  int snap2 [2];
  int snap3 [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_rdy[i] = 0; n_wc[i] = 0; n_ov[i] = 0; n_wp[i] = 0;
      last_rdy[i] = -1; last_wc[i] = -1; last_rdata[i] = 16'h0;
      busy_end[i] = 0; cur_known[i] = 1'b0; cur_mi[i] = 16'h0;
    end

    repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(2);

    // Write then read back with latency check
    rc = cyc;
    step(1'b0, 1'b1, 1'b1, 16'h0200, 16'hBEEF);
    idle(5);
    chk("t1_wc_latency", 0, 32'(last_wc[0] - rc), 32'd3);
    chk("t1_wc_latency", 1, 32'(last_wc[1] - rc), 32'd2);
    chk("t1_wc_count", 0, 32'(n_wc[0]), 32'd1);
    rc = cyc;
    step(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0);
    idle(5);
    for (int i = 0; i < 2; i++) begin
      chk("t1_read_data", i, 32'(last_rdata[i]), 32'hBEEF);
      chk("t1_rdy_latency", i, 32'(last_rdy[i] - rc), 32'(lat(i) + 1));
    end

    // Address aliasing modulo 4096 words
    step(1'b0, 1'b1, 1'b1, 16'h0005, 16'h1234);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 16'h1005, 16'h0);
    idle(5);
    for (int i = 0; i < 2; i++) chk("t2_alias_data", i, 32'(last_rdata[i]), 32'h1234);

    // Back-to-back request is dropped with a single overrun
    for (int i = 0; i < 2; i++) begin snap[i] = n_ov[i]; snap2[i] = n_rdy[i]; end
    step(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0);
    idle(6);
    for (int i = 0; i < 2; i++) begin
      chk("t3_overrun_count", i, 32'(n_ov[i] - snap[i]), 32'd1);
      chk("t3_ready_count", i, 32'(n_rdy[i] - snap2[i]), 32'd1);
      chk("t3_first_addr_data", i, 32'(last_rdata[i]), 32'hBEEF);
    end

    // Reset during WAIT abandons the write
    step(1'b0, 1'b1, 1'b1, 16'h0300, 16'h7777);
    idle(5);
    for (int i = 0; i < 2; i++) snap[i] = n_wc[i];
    step(1'b0, 1'b1, 1'b1, 16'h0300, 16'hAAAA);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 16'h0300, 16'h0);
    idle(5);
    for (int i = 0; i < 2; i++) begin
      chk("t4_no_wc_after_reset", i, 32'(n_wc[i] - snap[i]), 32'd0);
      chk("t4_prior_value", i, 32'(last_rdata[i]), 32'h7777);
    end

    // Write protection below 0x0100 (word 0x080 seeded through its alias 0x1080)
    for (int i = 0; i < 2; i++) snap3[i] = n_wp[i];
    step(1'b0, 1'b1, 1'b1, 16'h1080, 16'h1111);
    idle(4);
    step(1'b0, 1'b1, 1'b1, 16'h0080, 16'h5555);
    idle(4);
    step(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0);
    idle(4);
    for (int i = 0; i < 2; i++) begin
`ifdef X3Q16_MEM_WPROT_EN
      chk("t5_blocked_data", i, 32'(last_rdata[i]), 32'h1111);
      chk("t5_wprot_count", i, 32'(n_wp[i] - snap3[i]), 32'd1);
`else
      chk("t5_unprotected_data", i, 32'(last_rdata[i]), 32'h5555);
      chk("t5_wprot_count", i, 32'(n_wp[i] - snap3[i]), 32'd0);
`endif
      snap3[i] = n_wp[i];
    end
    step(1'b0, 1'b1, 1'b1, 16'h0100, 16'h5555);
    idle(4);
    step(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0);
    idle(4);
    for (int i = 0; i < 2; i++) begin
      chk("t5_limit_commit", i, 32'(last_rdata[i]), 32'h5555);
      chk("t5_limit_no_wprot", i, 32'(n_wp[i] - snap3[i]), 32'd0);
    end

    // Core-style back-to-back read/write/read, each issued as soon as the bus frees
    step(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 16'h0200, 16'hC0DE);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0);
    idle(5);
    chk("t6_read_after_write", 1, 32'(last_rdata[1]), 32'hC0DE);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      logic        r  = ($urandom_range(0, 99) == 0);
      logic        rq = ($urandom_range(0, 2) == 0);
      logic        ty = 1'($urandom_range(0, 1));
      logic [15:0] ad = {4'($urandom_range(0, 15)), 8'h00, 4'($urandom_range(0, 15))};
      logic [15:0] dt = 16'($urandom);
      step(r, rq, ty, ad, dt);
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
